// File: rtl/zeroriscy_defines.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_defines (package)
// Purpose  : Shared encodings for the zero-riscy CSR port: CSR operation codes
//            and the state type of the debug CSR master FSM.
// Contents : CSR_OP_* codes, DbgCsrState_t, csr_access_op() helper.
// Revision : 1.0 - initial release
// ============================================================================
package zeroriscy_defines;

    localparam logic [1:0] CSR_OP_NONE  = 2'd0;
    localparam logic [1:0] CSR_OP_WRITE = 2'd1;
    localparam logic [1:0] CSR_OP_SET   = 2'd2;
    localparam logic [1:0] CSR_OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        DBG_IDLE      = 2'd0,
        DBG_WAIT_PORT = 2'd1,
        DBG_ACCESS    = 2'd2,
        DBG_RESP      = 2'd3
    } DbgCsrState_t;

    // Reads never modify the CSR, so they present CSR_OP_NONE on the port.
    function automatic logic [1:0] csr_access_op(input logic we, input logic [1:0] op);
        return we ? op : CSR_OP_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zeroriscy_csr_dbg_master.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_csr_dbg_master
// Purpose  : Debug-side master for the core CSR port. Accepts a single write
//            or a burst read, waits for the core to release the CSR port,
//            performs one access per beat and returns one response per beat.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            dbg_req_i .. dbg_len_i    - debug request (addr, we, wdata, op, len)
//            dbg_gnt_o                 - request accepted (only in IDLE)
//            dbg_rvalid_o/rlast/err    - response beat strobe, last beat, error
//            dbg_rdata_o               - response data (held between beats)
//            core_csr_busy_i           - core owns the CSR port this cycle
//            csr_sel_o .. csr_op_o     - CSR port drive (non-zero only in ACCESS)
//            csr_rdata_i               - combinational CSR read data
// Revision : 1.0 - initial release
// ============================================================================
module zeroriscy_csr_dbg_master
    import zeroriscy_defines::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_BURST      = 32,
    localparam int LEN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dbg_req_i,
    input  logic             dbg_we_i,
    input  logic [11:0]      dbg_addr_i,
    input  logic [31:0]      dbg_wdata_i,
    input  logic [1:0]       dbg_op_i,
    input  logic [LEN_W-1:0] dbg_len_i,
    output logic             dbg_gnt_o,
    output logic             dbg_rvalid_o,
    output logic             dbg_rlast_o,
    output logic             dbg_err_o,
    output logic [31:0]      dbg_rdata_o,
    input  logic             core_csr_busy_i,
    output logic             csr_sel_o,
    output logic             csr_access_o,
    output logic [11:0]      csr_addr_o,
    output logic [31:0]      csr_wdata_o,
    output logic [1:0]       csr_op_o,
    input  logic [31:0]      csr_rdata_i
);

    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] c_tcnt_max = TCW'(TIMEOUT_CYCLES - 1);

    DbgCsrState_t     r_state;
    DbgCsrState_t     w_state_nxt;

    logic [11:0]      r_addr;
    logic             r_we;
    logic [31:0]      r_wdata;
    logic [1:0]       r_op;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat;
    logic [TCW-1:0]   r_tcnt;
    logic [31:0]      r_rdata;
    logic             r_last;
    logic             r_err;

    logic             w_bad_write;
    logic             w_beat_last;
    logic             w_timeout;

    // A write is a single beat with a real op; anything else is rejected
    // without touching the CSR port.
    assign w_bad_write = r_we && ((r_op == CSR_OP_NONE) || (r_len != '0));
    assign w_beat_last = (r_beat == r_len);
    assign w_timeout   = core_csr_busy_i && (r_tcnt == c_tcnt_max);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DBG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and CSR port / grant outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        dbg_gnt_o    = 1'b0;
        csr_sel_o    = 1'b0;
        csr_access_o = 1'b0;
        csr_addr_o   = 12'd0;
        csr_wdata_o  = 32'd0;
        csr_op_o     = CSR_OP_NONE;
        case (r_state)
            DBG_IDLE: begin
                dbg_gnt_o = dbg_req_i & ~rst;
                if (dbg_req_i) begin
                    w_state_nxt = DBG_WAIT_PORT;
                end
            end
            DBG_WAIT_PORT: begin
                if (w_bad_write) begin
                    w_state_nxt = DBG_RESP;
                end else if (!core_csr_busy_i) begin
                    w_state_nxt = DBG_ACCESS;
                end else if (w_timeout) begin
                    w_state_nxt = DBG_RESP;
                end
            end
            DBG_ACCESS: begin
                // Port already owned: core_csr_busy_i is deliberately ignored.
                csr_sel_o    = 1'b1;
                csr_access_o = 1'b1;
                csr_addr_o   = r_addr;
                csr_wdata_o  = r_we ? r_wdata : 32'd0;
                csr_op_o     = csr_access_op(r_we, r_op);
                w_state_nxt  = DBG_RESP;
            end
            DBG_RESP: begin
                w_state_nxt = r_last ? DBG_IDLE : DBG_WAIT_PORT;
            end
            default: begin
                w_state_nxt = DBG_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latches, beat/timeout counters and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= 12'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_op    <= CSR_OP_NONE;
            r_len   <= '0;
            r_beat  <= '0;
            r_tcnt  <= '0;
            r_rdata <= 32'd0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                DBG_IDLE: begin
                    if (dbg_req_i) begin
                        r_addr  <= dbg_addr_i;
                        r_we    <= dbg_we_i;
                        r_wdata <= dbg_wdata_i;
                        r_op    <= dbg_op_i;
                        r_len   <= dbg_len_i;
                        r_beat  <= '0;
                        r_tcnt  <= '0;
                        r_last  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                DBG_WAIT_PORT: begin
                    if (w_bad_write || w_timeout) begin
                        // Error beat terminates the request; remaining beats dropped.
                        r_err   <= 1'b1;
                        r_last  <= 1'b1;
                        r_rdata <= 32'd0;
                    end else if (!core_csr_busy_i) begin
                        r_err   <= 1'b0;
                        r_last  <= w_beat_last;
                    end else begin
                        r_tcnt  <= r_tcnt + 1'b1;
                    end
                end
                DBG_ACCESS: begin
                    r_rdata <= csr_rdata_i;
                end
                DBG_RESP: begin
                    if (!r_last) begin
                        r_addr <= r_addr + 12'd1;
                        r_beat <= r_beat + 1'b1;
                        r_tcnt <= '0;
                    end
                end
                default: begin
                    r_tcnt <= '0;
                end
            endcase
        end
    end

    assign dbg_rvalid_o = (r_state == DBG_RESP);
    assign dbg_rlast_o  = dbg_rvalid_o & r_last;
    assign dbg_err_o    = dbg_rvalid_o & r_err;
    assign dbg_rdata_o  = r_rdata;

endmodule
`default_nettype wire
